// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: N-requester round-robin arbiter with registered one-hot grants.
// Define ARB_TIMEOUT_EN to preempt a holder after MAXHOLD cycles under contention.
module rr_arbiter_n #(
  parameter int N = 4,
  parameter int IW = 2,
  parameter int MAXHOLD = 8
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic [N-1:0]  r,
  output logic [N-1:0]  g,
  output logic [IW-1:0] gid,
  output logic          busy,
  output logic          timeout
);
  typedef enum logic {IDLE, GNT} state_t;
  state_t state;
  logic [IW-1:0] ptr, base, sel;
  logic [N-1:0] cand;
  logic found, rel, to, switch_grant;
  int idx;
  // While granted, the scan starts just past the holder and excludes it
  assign base = (state == GNT) ? ((int'(gid) == N-1) ? '0 : gid + 1'b1) : ptr;
  assign cand = r & ~g;
  assign found = |cand;
  assign rel = (state == GNT) && !(|(r & g));
  always_comb begin
    sel = '0;
    idx = 0;
    for (int i = N-1; i >= 0; i--) begin
      idx = (int'(base) + i >= N) ? int'(base) + i - N : int'(base) + i;
      sel = cand[idx] ? IW'(idx) : sel;
    end
  end
`ifdef ARB_TIMEOUT_EN
  logic [7:0] hcnt;
  assign to = (state == GNT) && !rel && (hcnt == 8'(MAXHOLD-1)) && found;
`else
  logic unused_maxhold;
  assign unused_maxhold = MAXHOLD > 0;
  assign to = 1'b0;
`endif
  assign switch_grant = (state == IDLE) ? |r : (rel || to);
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= IDLE;
      ptr <= '0;
      g <= '0;
      gid <= '0;
      busy <= 1'b0;
      timeout <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hcnt <= '0;
`endif
    end else begin
      timeout <= to;
      if (switch_grant) begin
        if (state == GNT) ptr <= base;
        state <= found ? GNT : IDLE;
        g <= found ? N'(1) << sel : '0;
        gid <= found ? sel : '0;
        busy <= found;
`ifdef ARB_TIMEOUT_EN
        hcnt <= '0;
      end else if (state == GNT && hcnt != 8'(MAXHOLD-1)) begin
        hcnt <= hcnt + 8'd1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_rr_arbiter_n.sv
// tb_rr_arbiter_n: vector table, hand sequences and randomized model check for rr_arbiter_n.
module tb_rr_arbiter_n;
  localparam int N = 4, IW = 2, MAXHOLD = 3;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif
  logic Clock = 1'b0, Resetn = 1'b0;
  logic [N-1:0] r = '0, g;
  logic [IW-1:0] gid;
  logic busy, timeout;
  int checks = 0, errors = 0;
  typedef struct { logic [N-1:0] r; logic [N-1:0] g; } vec_t;
  vec_t tbl[15];

  rr_arbiter_n #(.N(N), .IW(IW), .MAXHOLD(MAXHOLD)) dut (
    .Clock(Clock), .Resetn(Resetn), .r(r), .g(g), .gid(gid), .busy(busy), .timeout(timeout)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [N-1:0] eg, input logic et);
    logic [IW-1:0] egid;
    egid = '0;
    for (int i = 0; i < N; i++) if (eg[i]) egid = IW'(i);
    checks++;
    if ({g, gid, busy, timeout} !== {eg, egid, |eg, et}) begin
      errors++;
      $display("FAIL %s: got g=%b gid=%0d busy=%b timeout=%b, want g=%b gid=%0d busy=%b timeout=%b",
               name, g, gid, busy, timeout, eg, egid, |eg, et);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    r = '0;
    Resetn = 1'b0;
    tick();
    Resetn = 1'b1;
  endtask

  function automatic int pick(input logic [N-1:0] rv, input int start);
    for (int j = 0; j < N; j++) if (rv[(start + j) % N]) return (start + j) % N;
    return -1;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int holder, mptr, ten;
    logic mto;
    logic [N-1:0] oth;
    tbl[0]  = '{4'b0000, 4'b0000};
    tbl[1]  = '{4'b1110, 4'b0010};
    tbl[2]  = '{4'b1110, 4'b0010};
    tbl[3]  = '{4'b1100, 4'b0100};
    tbl[4]  = '{4'b1000, 4'b1000};
    tbl[5]  = '{4'b1001, 4'b1000};
    tbl[6]  = '{4'b0001, 4'b0001};
    tbl[7]  = '{4'b0000, 4'b0000};
    tbl[8]  = '{4'b0000, 4'b0000};
    tbl[9]  = '{4'b1001, 4'b1000};
    tbl[10] = '{4'b0001, 4'b0001};
    tbl[11] = '{4'b0010, 4'b0010};
    tbl[12] = '{4'b0000, 4'b0000};
    tbl[13] = '{4'b0001, 4'b0001};
    tbl[14] = '{4'b0000, 4'b0000};

    #12;
    check("reset", '0, 1'b0);
    Resetn = 1'b1;
    for (int i = 0; i < 15; i++) begin
      r = tbl[i].r;
      tick();
      check($sformatf("vec%0d", i), tbl[i].g, 1'b0);
    end

    // rotation with every requester active, no idle bubble between tenures
    do_reset();
    r = 4'b1111;
    tick();
    check("rot_first", 4'b0001, 1'b0);
    for (int h = 0; h < N; h++) begin
      r = 4'b1111;
      tick();
      check($sformatf("rot_hold%0d", h), N'(1) << h, 1'b0);
      r = 4'b1111 & ~(N'(1) << h);
      tick();
      check($sformatf("rot_next%0d", h), N'(1) << ((h + 1) % N), 1'b0);
    end

    // forced rotation after MAXHOLD cycles of contention
    do_reset();
    r = 4'b0001;
    tick();
    check("to_grant", 4'b0001, 1'b0);
    r = 4'b0101;
    tick();
    check("to_hold2", 4'b0001, 1'b0);
    tick();
    check("to_hold3", 4'b0001, 1'b0);
    tick();
    check("to_switch", TO ? 4'b0100 : 4'b0001, TO);
    tick();
    check("to_after", TO ? 4'b0100 : 4'b0001, 1'b0);
    r = 4'b0000;
    tick();
    check("to_release", 4'b0000, 1'b0);

    // lone requester keeps the grant and never times out
    do_reset();
    r = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("single%0d", i), 4'b0010, 1'b0);
    end
    r = 4'b0000;
    tick();
    check("single_rel", 4'b0000, 1'b0);
    tick();
    check("single_idle", 4'b0000, 1'b0);

    // asynchronous reset in the middle of a grant
    do_reset();
    r = 4'b0100;
    tick();
    check("async_pre", 4'b0100, 1'b0);
    #2;
    Resetn = 1'b0;
    #1;
    check("async_rst", 4'b0000, 1'b0);
    r = 4'b0000;
    #3;
    Resetn = 1'b1;
    tick();
    check("async_after", 4'b0000, 1'b0);

    // randomized traffic against a tenure-based reference model
    do_reset();
    holder = -1;
    mptr = 0;
    ten = 0;
    for (int c = 0; c < 3000; c++) begin
      r = N'($urandom_range(0, 15));
      if (holder >= 0 && $urandom_range(0, 3) != 0) r[holder] = 1'b1;
      mto = 1'b0;
      if (holder < 0) begin
        holder = pick(r, mptr);
        ten = 1;
      end else if (!r[holder]) begin
        mptr = (holder + 1) % N;
        holder = pick(r, mptr);
        ten = 1;
      end else begin
        oth = r;
        oth[holder] = 1'b0;
        if (TO && ten >= MAXHOLD && oth != '0) begin
          mptr = (holder + 1) % N;
          holder = pick(oth, mptr);
          ten = 1;
          mto = 1'b1;
        end else ten++;
      end
      tick();
      check($sformatf("rand%0d", c), holder < 0 ? '0 : N'(1) << holder, mto);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
